// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle magnitude comparator: walks two latched operands MSB-first through a
// single 2-bit compare cell, optionally stopping at the first slice that decides the result.
module serial_cmp_ctrl #(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int NS        = (N + 1) / 2,
    localparam int SW        = $clog2(NS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          eq,
    input  logic          gt,
    output logic          busy,
    output logic          done,
    output logic          EQ,
    output logic          GT,
    output logic [SW-1:0] slices
);

    localparam int W  = 2 * NS;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          eq_acc;
    logic          gt_acc;
    logic [IW-1:0] idx;
    logic [SW-1:0] cnt;
    logic [1:0]    a_s;
    logic [1:0]    b_s;
    logic          slice_eq;
    logic          slice_gt;
    logic          last;
    logic          accept;

    // The one compare cell: select the current slice and decide whether this is the final step.
    always_comb begin
        a_s      = 2'(a_r >> {idx, 1'b0});
        b_s      = 2'(b_r >> {idx, 1'b0});
        slice_eq = (a_s == b_s);
        slice_gt = (a_s > b_s);
        last     = (idx == '0) || (EARLY_EXIT && !slice_eq);
        accept   = start && (state != S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = eq ? S_RUN : S_DONE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Result registers are only written when a result is produced, so they hold through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            eq_acc <= 1'b0;
            gt_acc <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
            EQ     <= 1'b0;
            GT     <= 1'b0;
            slices <= '0;
        end else if (accept) begin
            a_r    <= W'(a);
            b_r    <= W'(b);
            eq_acc <= eq;
            gt_acc <= gt;
            idx    <= IW'(NS - 1);
            cnt    <= '0;
            if (!eq) begin
                EQ     <= 1'b0;
                GT     <= gt;
                slices <= '0;
            end
        end else if (state == S_RUN) begin
            eq_acc <= eq_acc & slice_eq;
            gt_acc <= gt_acc | (eq_acc & slice_gt);
            cnt    <= cnt + SW'(1);
            if (last) begin
                EQ     <= eq_acc & slice_eq;
                GT     <= gt_acc | (eq_acc & slice_gt);
                slices <= cnt + SW'(1);
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Multi-cycle magnitude comparator sequencer.
- Latches two N-bit operands and evaluates them MSB-first, one 2-bit slice per clock.
- Uses a single internal 2-bit compare cell (slice EQ/GT cascade semantics) instead of an (N+1)/2-cell ripple chain, trading latency for area.
- Terminates early once the result is decided; reports completion with a one-cycle done pulse.

Parameters:
- N, 8, operand width in bits (N >= 1); NS = (N+1)/2 slices; odd N zero-pads a[N]/b[N].
- EARLY_EXIT, 1, 1 = stop at first unequal slice; 0 = always walk all NS slices.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- start  in  1  request; sampled when busy=0.
- a  in  N  operand A, captured on accepted start.
- b  in  N  operand B, captured on accepted start.
- eq  in  1  cascade equal-in, captured on accepted start.
- gt  in  1  cascade greater-in, captured on accepted start.
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse: EQ/GT/slices valid.
- EQ  out  1  result: eq & (a==b).
- GT  out  1  result: gt | (eq & a>b), unsigned.
- slices  out  clog2(NS+1)  number of slices evaluated for the last result.

Behaviour:
- Clocking/reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, EQ=0, GT=0, slices=0. Internal regs cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Start acceptance: start=1 on an edge in IDLE or DONE is accepted.
  - Capture a, b (zero-padded to 2*NS bits), eq -> eq_acc, gt -> gt_acc.
  - Set idx=NS-1 and cnt=0.
  - If eq=0: go to DONE with EQ=0, GT=gt, slices=0. No RUN cycles.
  - Otherwise go to RUN.
- start in RUN is ignored and has no effect on captured data.
- RUN, each edge, slice s = bits [2*idx+1 : 2*idx]:
  - eq_acc <= eq_acc & (a_s == b_s).
  - gt_acc <= gt_acc | (eq_acc & (a_s > b_s)).
  - cnt <= cnt+1.
- RUN exit:
  - If idx==0, or (EARLY_EXIT and a_s != b_s): go to DONE, drive EQ/GT from the updated accumulators, slices = cnt+1.
  - Otherwise idx <= idx-1 and stay in RUN.
- Timing: start accepted at edge E0. Slice NS-1 is evaluated at E1; a slice decided at E_k gives done=1 in the cycle after E_k.
  - Full walk: done appears NS cycles after the start edge.
  - Early exit at slice NS-k: done appears k cycles after the start edge.
- DONE lasts exactly one cycle, then returns to IDLE unless a new start is accepted on that edge (back-to-back allowed, no bubble).
- EQ, GT and slices hold their values from done until the next result is written. They do not change during RUN.
- EARLY_EXIT=0: final EQ/GT are identical to the early-exit result; only slices (=NS) and latency differ.
- Mid-operation reset: rst asserted during RUN immediately forces all reset values. There is no done pulse and the partial result is discarded.
- Start on the first edge after rst deasserts is accepted normally.

Test Plan:
- N=8, a=0xA5, b=0xA5, eq=1, gt=0, start 1 cycle -> busy 4 cycles; done 4 cycles after start edge; EQ=1, GT=0, slices=4.
- N=8, a=0xC0, b=0x80, eq=1, gt=0 -> top slice 11>10 decides; done 1 cycle after start; EQ=0, GT=1, slices=1. With EARLY_EXIT=0: same EQ/GT, slices=4, done after 4 cycles.
- N=8, a=0x12, b=0x13, eq=1, gt=1 -> differs in slice 0 only; EQ=0, GT=1 (gt_in dominates), slices=4. Repeat with gt=0 -> GT=0.
- eq=0, gt=1, any a/b -> no RUN; done next cycle; EQ=0, GT=1, slices=0.
- start pulsed again during RUN with different a/b -> ignored; result matches the first operands. start held high through DONE -> second comparison begins with no idle cycle.
- N=5: a=5'b10000, b=5'b01111 -> NS=3, padded top slice {0,1} vs {0,0}; done after 1 cycle, GT=1. Reset asserted 2 cycles into a full-walk compare -> busy/done/EQ/GT/slices all 0 immediately; no done pulse follows.
